// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multicycle signed MULT/DIV coprocessor owning HI/LO
`timescale 1ns/1ps
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, MULT_RUN, DIV_RUN, FIX, FINISH} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 op_r;
  logic                 dz_r;
  logic                 sign_a;
  logic                 sign_b;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH+1:0]   booth_acc;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     dvs;

  logic [WIDTH:0]       booth_hi_sum;
  logic [2*WIDTH+1:0]   booth_next;
  logic [WIDTH:0]       div_shifted;
  logic                 div_ge;
  logic [WIDTH-1:0]     rem_next;
  logic [WIDTH-1:0]     quo_next;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;

  assign abs_a = op_a[WIDTH-1] ? -op_a : op_a;
  assign abs_b = op_b[WIDTH-1] ? -op_b : op_b;

  // Upper partial product carries one guard bit so -2^(W-1) multiplicands cannot overflow.
  always_comb begin
    booth_hi_sum = booth_acc[2*WIDTH+1:WIDTH+1];
    case (booth_acc[1:0])
      2'b01:   booth_hi_sum = booth_acc[2*WIDTH+1:WIDTH+1] + {mcand[WIDTH-1], mcand};
      2'b10:   booth_hi_sum = booth_acc[2*WIDTH+1:WIDTH+1] - {mcand[WIDTH-1], mcand};
      default: booth_hi_sum = booth_acc[2*WIDTH+1:WIDTH+1];
    endcase
    booth_next = {booth_hi_sum[WIDTH], booth_hi_sum, booth_acc[WIDTH:1]};
  end

  always_comb begin
    div_shifted = {rem, quo[WIDTH-1]};
    div_ge      = (div_shifted >= {1'b0, dvs});
    rem_next    = div_ge ? (div_shifted[WIDTH-1:0] - dvs) : div_shifted[WIDTH-1:0];
    quo_next    = {quo[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_r      <= 1'b0;
      dz_r      <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      mcand     <= '0;
      booth_acc <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r      <= op;
            sign_a    <= op_a[WIDTH-1];
            sign_b    <= op_b[WIDTH-1];
            mcand     <= op_a;
            booth_acc <= {{(WIDTH+1){1'b0}}, op_b, 1'b0};
            rem       <= '0;
            quo       <= abs_a;
            dvs       <= abs_b;
            cnt       <= CW'(WIDTH);
            if (op && (op_b == '0)) begin
              dz_r  <= 1'b1;
              state <= FINISH;
            end else begin
              dz_r  <= 1'b0;
              busy  <= 1'b1;
              state <= op ? DIV_RUN : MULT_RUN;
            end
          end
        end
        MULT_RUN: begin
          booth_acc <= booth_next;
          cnt       <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FINISH;
        end
        DIV_RUN: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (sign_a ^ sign_b) quo <= -quo;
          if (sign_a) rem <= -rem;
          state <= FINISH;
        end
        FINISH: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          div_zero <= dz_r;
          if (!dz_r) begin
            if (op_r) begin
              hi <= rem;
              lo <= quo;
            end else begin
              hi <= booth_acc[2*WIDTH:WIDTH+1];
              lo <= booth_acc[WIDTH:1];
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
